// File: rtl/cpu_axi_pkg.sv
// Shared AXI constants and small types used by the CPU-side AXI bridges.
package cpu_axi_pkg;

  localparam int          ID_W       = 4;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  SIZE_WORD  = 2'b10;
  localparam logic [7:0]  LEN_SINGLE = 8'd0;

  typedef logic [ID_W-1:0] axi_id_t;

  // AXI ARSIZE is 3 bits; the SRAM-side size only ever covers 1/2/4 bytes.
  function automatic logic [2:0] to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side SRAM-like to AXI4 read bridge: one registered AR slot,
// bounded outstanding reads, in-order single-beat returns.
module inst_axi_rd_bridge
  import cpu_axi_pkg::*;
#(
  parameter int      MAX_OUTSTANDING = 2,
  parameter axi_id_t ARID_VAL        = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             ar_valid_q;
  logic [31:0]      ar_addr_q;
  logic [1:0]       ar_size_q;
  logic [CNT_W-1:0] out_cnt;

  logic ar_fire;
  logic r_fire;
  logic accept;
  logic cnt_room;

  // Write-side inputs and response status have no role in an instruction
  // read path; rresp errors still hand their data to the fetch stage.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp};

  // Fetch always accepts returning data, so R is ready whenever out of reset.
  assign rready  = resetn;
  assign ar_fire = ar_valid_q & arready;
  assign r_fire  = rvalid & rready;

  // A slot frees up either because it is empty or because it fires this
  // cycle; a full counter is relieved by a same-cycle return.
  assign cnt_room = (out_cnt < MAX_CNT) | r_fire;
  assign accept   = resetn & inst_sram_req & (~ar_valid_q | arready) & cnt_room;

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = r_fire;
  assign inst_sram_rdata   = rdata;

  assign arid    = ARID_VAL;
  assign araddr  = ar_addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = to_axsize(ar_size_q);
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = ar_valid_q;

  // AR slot: load on accept, drain on handshake, hold while stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= 32'h0;
      ar_size_q  <= SIZE_WORD;
    end else if (accept) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= inst_sram_addr;
      ar_size_q  <= inst_sram_size;
    end else if (ar_fire) begin
      ar_valid_q <= 1'b0;
    end
  end

  // Outstanding-read counter; a stray return at zero leaves it at zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_cnt <= '0;
    end else if (accept && !r_fire) begin
      out_cnt <= out_cnt + CNT_ONE;
    end else if (r_fire && !accept && out_cnt != '0) begin
      out_cnt <= out_cnt - CNT_ONE;
    end
  end

  // A return with nothing outstanding means the slave or fabric misbehaved.
  a_no_stray_return: assert property (@(posedge clk) disable iff (!resetn)
    r_fire |-> (out_cnt != '0));

  // Single-ID, single-beat traffic only.
  a_rid_match: assert property (@(posedge clk) disable iff (!resetn)
    r_fire |-> (rid == ARID_VAL));

  a_rlast_set: assert property (@(posedge clk) disable iff (!resetn)
    r_fire |-> rlast);

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge with MAX_OUTSTANDING = 2.
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .ARID_VAL(4'h0)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] BASE = 32'h1C00_0000;

  initial begin
    resetn          = 1'b0;
    inst_sram_req   = 1'b1;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'b10;
    inst_sram_wstrb = 4'h0;
    inst_sram_addr  = 32'h1234_5678;
    inst_sram_wdata = 32'h0;
    arready         = 1'b0;
    rid             = 4'h0;
    rdata           = 32'h0;
    rresp           = 2'b00;
    rlast           = 1'b1;
    rvalid          = 1'b0;

    // Reset state, with a request pending to show it is not accepted.
    cyc(); cyc();
    mid();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_arsize", 32'(arsize), 32'd2);
    check("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    check("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_out_cnt", 32'(dut.out_cnt), 32'd0);
    check("const_arlen", 32'(arlen), 32'd0);
    check("const_arburst", 32'(arburst), 32'd1);
    check("const_arid", 32'(arid), 32'd0);

    cyc(); resetn = 1'b1; inst_sram_req = 1'b0;
    mid();
    check("rready_on", 32'(rready), 32'd1);

    // Single fetch.
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = BASE;
    mid();
    check("sf_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_req = 1'b0; arready = 1'b1;
    mid();
    check("sf_arvalid", 32'(arvalid), 32'd1);
    check("sf_araddr", araddr, BASE);
    check("sf_arsize", 32'(arsize), 32'd2);
    check("sf_cnt1", 32'(dut.out_cnt), 32'd1);
    cyc(); arready = 1'b0;
    mid();
    check("sf_arvalid_clr", 32'(arvalid), 32'd0);
    cyc(); rvalid = 1'b1; rdata = 32'h0280_0C0C;
    mid();
    check("sf_data_ok", 32'(inst_sram_data_ok), 32'd1);
    check("sf_rdata", inst_sram_rdata, 32'h0280_0C0C);
    cyc(); rvalid = 1'b0;
    mid();
    check("sf_data_ok_off", 32'(inst_sram_data_ok), 32'd0);
    check("sf_cnt0", 32'(dut.out_cnt), 32'd0);

    // Stalled AR channel.
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = BASE + 32'h100;
    mid();
    check("st_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(); inst_sram_addr = BASE + 32'h200;
      mid();
      check("st_hold_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
      check("st_hold_arvalid", 32'(arvalid), 32'd1);
      check("st_hold_araddr", araddr, BASE + 32'h100);
    end
    cyc(); arready = 1'b1;
    mid();
    check("st_fire_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_req = 1'b0;
    mid();
    check("st_next_araddr", araddr, BASE + 32'h200);
    check("st_cnt2", 32'(dut.out_cnt), 32'd2);
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
    mid();
    check("st_r1_data_ok", 32'(inst_sram_data_ok), 32'd1);
    check("st_r1_rdata", inst_sram_rdata, 32'h1111_1111);
    check("st_r1_arvalid", 32'(arvalid), 32'd0);
    cyc(); rdata = 32'h2222_2222;
    mid();
    check("st_r2_cnt", 32'(dut.out_cnt), 32'd1);
    cyc(); rvalid = 1'b0;
    mid();
    check("st_cnt0", 32'(dut.out_cnt), 32'd0);

    // Outstanding limit.
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = BASE + 32'h300; arready = 1'b1;
    mid();
    check("lim_a_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_addr = BASE + 32'h304;
    mid();
    check("lim_b_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_addr = BASE + 32'h308;
    mid();
    check("lim_c_blocked", 32'(inst_sram_addr_ok), 32'd0);
    check("lim_cnt_full", 32'(dut.out_cnt), 32'd2);
    check("lim_araddr_b", araddr, BASE + 32'h304);
    cyc(); rvalid = 1'b1; rdata = 32'h3333_3333;
    mid();
    check("lim_c_ok_on_r", 32'(inst_sram_addr_ok), 32'd1);
    check("lim_data_ok", 32'(inst_sram_data_ok), 32'd1);
    cyc(); inst_sram_req = 1'b0; rdata = 32'h4444_4444;
    mid();
    check("lim_cnt_stays", 32'(dut.out_cnt), 32'd2);
    check("lim_araddr_c", araddr, BASE + 32'h308);
    check("lim_arvalid_c", 32'(arvalid), 32'd1);
    cyc(); rdata = 32'h5555_5555;
    mid();
    check("lim_cnt_1", 32'(dut.out_cnt), 32'd1);
    cyc(); rvalid = 1'b0; arready = 1'b0;
    mid();
    check("lim_cnt_0", 32'(dut.out_cnt), 32'd0);

    // Streaming: one request per cycle, R one cycle after each AR.
    arready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      inst_sram_req  = (i < 8);
      inst_sram_addr = BASE + 32'(4 * i);
      rvalid         = (i >= 2);
      rdata          = 32'hA000_0000 + 32'(i) - 32'd2;
      mid();
      check("str_addr_ok", 32'(inst_sram_addr_ok), (i < 8) ? 32'd1 : 32'd0);
      check("str_data_ok", 32'(inst_sram_data_ok), (i >= 2) ? 32'd1 : 32'd0);
      check("str_arvalid", 32'(arvalid), (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 8) check("str_araddr", araddr, BASE + 32'(4 * (i - 1)));
    end
    cyc(); inst_sram_req = 1'b0; rvalid = 1'b0; arready = 1'b0;
    mid();
    check("str_cnt0", 32'(dut.out_cnt), 32'd0);

    // Error response still returns data.
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = BASE + 32'h400;
    mid();
    check("err_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_req = 1'b0; arready = 1'b1;
    mid();
    cyc(); arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    mid();
    check("err_data_ok", 32'(inst_sram_data_ok), 32'd1);
    check("err_rdata", inst_sram_rdata, 32'hDEAD_BEEF);
    check("err_cnt1", 32'(dut.out_cnt), 32'd1);
    cyc(); rvalid = 1'b0; rresp = 2'b00;
    mid();
    check("err_cnt0", 32'(dut.out_cnt), 32'd0);

    // Reset mid-operation with two outstanding and an occupied AR slot.
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = BASE + 32'h500; arready = 1'b1;
    mid();
    check("rm_a_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_addr = BASE + 32'h504;
    mid();
    check("rm_b_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_req = 1'b0; arready = 1'b0; resetn = 1'b0; rvalid = 1'b1; rdata = 32'h6666_6666;
    mid();
    check("rm_pre_arvalid", 32'(arvalid), 32'd1);
    check("rm_pre_cnt", 32'(dut.out_cnt), 32'd2);
    check("rm_rready", 32'(rready), 32'd0);
    check("rm_no_data_ok", 32'(inst_sram_data_ok), 32'd0);
    cyc();
    mid();
    check("rm_arvalid", 32'(arvalid), 32'd0);
    check("rm_cnt", 32'(dut.out_cnt), 32'd0);
    check("rm_araddr", araddr, 32'h0);
    check("rm_data_ok", 32'(inst_sram_data_ok), 32'd0);
    cyc(); resetn = 1'b1; rvalid = 1'b0;
    mid();
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = BASE + 32'h600;
    mid();
    check("rm_recover_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc(); inst_sram_req = 1'b0; arready = 1'b1;
    mid();
    check("rm_recover_cnt", 32'(dut.out_cnt), 32'd1);
    check("rm_recover_araddr", araddr, BASE + 32'h600);
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h7777_7777;
    mid();
    check("rm_recover_data_ok", 32'(inst_sram_data_ok), 32'd1);
    cyc(); rvalid = 1'b0;
    mid();
    check("rm_recover_cnt0", 32'(dut.out_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
# inst_axi_rd_bridge

Read-only bridge that converts the instruction-side SRAM-like request/`addr_ok`/`data_ok` protocol into AXI4 AR/R single-beat transactions. It sits directly upstream of the fetch stage: the fetch stage drives `inst_sram_*` into this block, and this block drives the AXI read channels toward the interconnect/memory. It holds one registered AR slot, tracks outstanding reads up to a fixed limit, and returns data in order.

## Interface
Parameters:
- MAX_OUTSTANDING, 2, maximum requests accepted (`addr_ok` given) but not yet returned (`data_ok` given); legal range 1..3.
- ARID_VAL, 4'h0, constant ARID driven on every request.

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- inst_sram_req  in  1  fetch request valid.
- inst_sram_wr  in  1  must be 0; ignored.
- inst_sram_size  in  2  bytes = 2^size; forwarded as ARSIZE.
- inst_sram_wstrb  in  4  ignored.
- inst_sram_addr  in  32  physical fetch address.
- inst_sram_wdata  in  32  ignored.
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok  out  1  read data valid this cycle.
- inst_sram_rdata  out  32  read data.
- arid  out  4  = ARID_VAL.
- araddr  out  32  registered address.
- arlen  out  8  = 0.
- arsize  out  3  = {1'b0, registered size}.
- arburst  out  2  = 2'b01.
- arlock  out  2  = 0.
- arcache  out  4  = 0.
- arprot  out  3  = 0.
- arvalid  out  1  AR slot occupied.
- arready  in  1  AXI AR ready.
- rid  in  4  ignored beyond ID match assertion.
- rdata  in  32  AXI read data.
- rresp  in  2  ignored for data path.
- rlast  in  1  always 1 for single-beat reads.
- rvalid  in  1  AXI R valid.
- rready  out  1  R ready.

## Operation
- State: `ar_valid_q`, `ar_addr_q[31:0]`, `ar_size_q[1:0]`, `out_cnt` (width ceil(log2(MAX_OUTSTANDING+1))).
- `ar_fire = arvalid & arready`; `r_fire = rvalid & rready`.
- `rready` is constant 1 once out of reset (fetch stage always accepts `data_ok`); `rready = resetn`.
- `inst_sram_addr_ok = inst_sram_req & (~ar_valid_q | arready) & (out_cnt < MAX_OUTSTANDING | r_fire)`.
- On `addr_ok`, latch addr/size into the AR slot and set `ar_valid_q`. On `ar_fire` without a new accept, clear `ar_valid_q`.
- `out_cnt` is +1 on `addr_ok`, −1 on `r_fire`, and unchanged when both happen. It never exceeds MAX_OUTSTANDING and never wraps below 0.
- `inst_sram_data_ok = r_fire`; `inst_sram_rdata = rdata` (combinational pass-through). `rresp` errors still return data.
- All requests use one ID, so AXI guarantees in-order return. There is no reordering buffer.
- Cancellation is the fetch stage's job: every accepted request returns exactly one `data_ok`.
- `r_fire` while `out_cnt == 0` is a protocol error; flag it with an assertion, and the counter stays at 0.

## Timing
- Reset values: `arvalid=0`, `araddr=0`, `arsize=3'b010`, `addr_ok=0`, `data_ok=0`, `rready=0`, `out_cnt=0`.
- Latency: request accepted at cycle T → `arvalid` high from T+1 until `arready`. Earliest `data_ok` is at T+2 (`arready` at T+1, `rvalid` at T+2).
- Back-to-back: a new `addr_ok` is allowed in the same cycle as `ar_fire`, which gives a throughput of one request per cycle when `arready` stays high and the counter permits.
- AR stability: `araddr`/`arsize` are held constant while `arvalid & ~arready`.
- Reset mid-operation: all state clears at the next edge and in-flight beats are dropped. The system reset also resets the AXI slave.

## Structure
- Shared package `cpu_axi_pkg`: AXI burst/size constants (BURST_INCR=2'b01) and the ID width.
- No sub-module is needed; the block is a single flat module.

## Test plan
- Single fetch: req addr 0x1C000000 at T, `arready=1` at T+1, `rvalid` with rdata 0x02800C0C at T+3 → `addr_ok`@T, `araddr`=0x1C000000@T+1, `data_ok`+rdata@T+3, `out_cnt` back to 0.
- Stalled AR: `arready=0` for 5 cycles → `arvalid`/`araddr` held stable, `addr_ok=0` for new requests until `ar_fire`.
- Outstanding limit (MAX=2): two accepted with `rvalid` withheld → third request gets `addr_ok=0`. One `rvalid` → `addr_ok=1` in that same cycle, and `out_cnt` stays at 2.
- Streaming: continuous req 0x1C000000, +4, +8… with `arready=1` and `rvalid` one cycle after each AR → one `addr_ok` and one `data_ok` per cycle, with rdata in order.
- Reset mid-operation: `resetn=0` with 2 outstanding and `arvalid=1` → next cycle `arvalid=0`, `out_cnt=0`, `rready=0`, and no `data_ok`.
- Error response: `rresp`=2'b10 with rdata 0xDEADBEEF → `data_ok=1`, rdata=0xDEADBEEF, and the counter decrements normally.
